vmmu_scan_fetch: RTL and testbench
==================================

Name: vmmu_scan_fetch

Overview:
- Read-side client of the video memory management unit. Walks a framebuffer linearly, one 3-byte RGB pixel per request.
- Pushes read addresses into the VMMU read request queue and pops the 3 returned bytes from the VMMU read data queue. Assembles them into 24-bit pixels and hands them to the scanout/timing stage over a valid/ready handshake.
- Runs on the memory clock; all VMMU queue strobes are generated as clean single-cycle pulses.

Parameters:
- AWIDTH, 18, memory address width.
- DWIDTH, 8, memory data width (byte).
- BASEADDR, 0, framebuffer start address.
- PIXCOUNT, 76800, pixels per frame (320x240).
- MAXINFLIGHT, 2, max requests issued but not yet fully popped; must keep 3*MAXINFLIGHT <= VMMU read buffer size.

Ports:
- MemClk  in  1  memory clock; all logic on rising edge.
- ResetN  in  1  synchronous reset, active low.
- FrameStart  in  1  one-cycle pulse; restart fetch from BASEADDR.
- ReadAddrOut  out  AWIDTH  read request address to VMMU.
- PushReadReq  out  1  request push strobe to VMMU.
- ReadReqQueueFull  in  1  VMMU request queue full.
- ReadDataIn  in  DWIDTH  head byte of VMMU read data queue.
- ReadDataQueueEmpty  in  1  VMMU read data queue empty.
- ReadDataClkOut  out  1  data pop strobe to VMMU.
- PixelOut  out  24  assembled pixel {byte0, byte1, byte2}; byte0 in [23:16].
- PixelValid  out  1  PixelOut holds a pixel.
- PixelReady  in  1  consumer accepts pixel.
- FrameDone  out  1  one-cycle pulse when the last frame pixel is accepted.

Behaviour:
- Reset (ResetN=0 at a clock edge) clears everything, including mid-pulse and mid-frame state:
  - PushReadReq=0, ReadDataClkOut=0, PixelValid=0, PixelOut=0, FrameDone=0, ReadAddrOut=BASEADDR.
  - Request counter=0, in-flight=0, byte index=0, fetch disabled.
  - Fetching starts only on FrameStart.
- Request FSM, states REQ_IDLE, REQ_PUSH, REQ_GAP:
  - REQ_IDLE -> REQ_PUSH when fetch enabled, requests issued < PIXCOUNT, ReadReqQueueFull=0 and in-flight < MAXINFLIGHT. ReadAddrOut is set in that same cycle.
  - REQ_PUSH: PushReadReq=1 for exactly one cycle; address held stable. Increment in-flight and the request counter.
  - REQ_GAP: PushReadReq=0 for one cycle, then advance ReadAddrOut by 3 and return to REQ_IDLE. Minimum request spacing is 3 cycles.
  - ReadAddrOut arithmetic is modulo 2^AWIDTH; it wraps silently.
- Data FSM, states DAT_WAIT, DAT_POP, DAT_GAP:
  - DAT_WAIT: when ReadDataQueueEmpty=0 and the pixel register can accept (PixelValid=0, or byte index != 2), latch ReadDataIn into byte slot[index], then go to DAT_POP.
  - DAT_POP: ReadDataClkOut=1 for one cycle.
  - DAT_GAP: ReadDataClkOut=0, index++. When index reaches 3: index=0, in-flight--, and PixelOut/PixelValid load the new pixel.
  - Sampling always precedes the pop strobe, never the reverse.
- Pixel handshake:
  - Transfer occurs when PixelValid&&PixelReady at a clock edge; PixelValid drops next cycle unless a new pixel loads in that same cycle.
  - PixelOut stays stable while PixelValid=1 and PixelReady=0.
- In-flight increment and decrement in the same cycle leave the count unchanged.
- Frame end: when pixel PIXCOUNT-1 transfers, FrameDone pulses for one cycle and fetch disables.
- FrameStart while in-flight > 0 or PixelValid=1 (abort):
  - Issue no new requests.
  - Keep popping all in-flight bytes but discard them; PixelValid is forced 0.
  - When in-flight reaches 0, reset the address and counter and restart.
  - FrameDone is suppressed for the aborted frame.
- FrameStart when idle: restart in the next cycle.

Optional Feature:
- Macro SCAN_FETCH_UNDERRUN_EN.
- Defined: adds output Underrun (1 bit) and a 16-bit saturating output UnderrunCount.
  - Underrun goes high for one cycle whenever PixelReady=1, PixelValid=0, fetch is enabled and the frame is incomplete.
  - UnderrunCount increments on each such cycle; it clears on reset and on FrameStart.
- Undefined: neither port exists; no logic is added.

Test Plan:
- Reset then FrameStart, PIXCOUNT=4, BASEADDR=0x100, queues always ready, PixelReady=1 -> PushReadReq pulses with addresses 0x100, 0x103, 0x106, 0x109; returned bytes 11,22,33 -> PixelOut=0x112233; FrameDone pulses once after the 4th pixel.
- ReadReqQueueFull=1 for 10 cycles mid-frame -> no PushReadReq during the stall; resumes with the next sequential address and no skip or duplicate.
- PixelReady=0 with data available, MAXINFLIGHT=2 -> at most 2 requests outstanding and PixelOut held stable; releasing PixelReady delivers pixels in order.
- FrameStart after 2 requests issued and 1 byte returned -> remaining 5 bytes popped and discarded, no PixelValid; next request address=BASEADDR; no FrameDone for the aborted frame.
- ResetN=0 while PushReadReq=1 -> next cycle all strobes 0, PixelValid=0, ReadAddrOut=BASEADDR; idle until FrameStart.
- With SCAN_FETCH_UNDERRUN_EN, hold ReadDataQueueEmpty=1 for 5 cycles with PixelReady=1 mid-frame -> UnderrunCount=5; with the macro undefined the build has no Underrun ports.

Source files
------------

// File: rtl/vmmu_scan_fetch_if.sv
// Bus bundle between vmmu_scan_fetch, the VMMU read queues and the scanout stage.
// master = the fetch block, slave = the VMMU/scanout side.
// Underrun/UnderrunCount exist only when SCAN_FETCH_UNDERRUN_EN is defined.
interface vmmu_scan_fetch_if #(
    parameter int AWIDTH = 18,
    parameter int DWIDTH = 8
);
    logic              FrameStart;
    logic [AWIDTH-1:0] ReadAddrOut;
    logic              PushReadReq;
    logic              ReadReqQueueFull;
    logic [DWIDTH-1:0] ReadDataIn;
    logic              ReadDataQueueEmpty;
    logic              ReadDataClkOut;
    logic [23:0]       PixelOut;
    logic              PixelValid;
    logic              PixelReady;
    logic              FrameDone;
`ifdef SCAN_FETCH_UNDERRUN_EN
    logic              Underrun;
    logic [15:0]       UnderrunCount;
`endif

    modport master (
        input  FrameStart, ReadReqQueueFull, ReadDataIn, ReadDataQueueEmpty, PixelReady,
        output ReadAddrOut, PushReadReq, ReadDataClkOut, PixelOut, PixelValid, FrameDone
`ifdef SCAN_FETCH_UNDERRUN_EN
        , output Underrun, UnderrunCount
`endif
    );

    modport slave (
        output FrameStart, ReadReqQueueFull, ReadDataIn, ReadDataQueueEmpty, PixelReady,
        input  ReadAddrOut, PushReadReq, ReadDataClkOut, PixelOut, PixelValid, FrameDone
`ifdef SCAN_FETCH_UNDERRUN_EN
        , input Underrun, UnderrunCount
`endif
    );
endinterface

// File: rtl/vmmu_scan_fetch.sv
// Purpose: linear framebuffer reader; one VMMU read request per 3-byte RGB pixel, pixels out on valid/ready.
// Latency: first push 2 cycles after FrameStart, pushes >= 3 cycles apart, each byte pop takes 3 cycles.
// Backpressure: requests stall on ReadReqQueueFull or MAXINFLIGHT; PixelOut held until PixelReady.
// Optional macro SCAN_FETCH_UNDERRUN_EN adds Underrun and the saturating UnderrunCount.
module vmmu_scan_fetch #(
    parameter int AWIDTH      = 18,
    parameter int DWIDTH      = 8,
    parameter int BASEADDR    = 0,
    parameter int PIXCOUNT    = 76800,
    parameter int MAXINFLIGHT = 2
) (
    input  logic MemClk,
    input  logic ResetN,
    vmmu_scan_fetch_if.master bus
);
    localparam int CW = $clog2(PIXCOUNT + 1);
    localparam int IW = $clog2(MAXINFLIGHT + 1);
    localparam logic [CW-1:0]     PIXTOTAL    = CW'(PIXCOUNT);
    localparam logic [CW-1:0]     PIXLAST     = CW'(PIXCOUNT - 1);
    localparam logic [IW-1:0]     INFLIGHTMAX = IW'(MAXINFLIGHT);
    localparam logic [AWIDTH-1:0] BASE        = AWIDTH'(BASEADDR);

    localparam logic [1:0] REQ_IDLE = 2'd0;
    localparam logic [1:0] REQ_PUSH = 2'd1;
    localparam logic [1:0] REQ_GAP  = 2'd2;
    localparam logic [1:0] DAT_WAIT = 2'd0;
    localparam logic [1:0] DAT_POP  = 2'd1;
    localparam logic [1:0] DAT_GAP  = 2'd2;

    logic [1:0]        reqState, datState;
    logic              pushReq, popStrobe;
    logic [AWIDTH-1:0] readAddr;
    logic [CW-1:0]     reqCount, pixCount;
    logic [IW-1:0]     inFlight;
    logic [1:0]        byteIdx;
    logic [DWIDTH-1:0] slot0, slot1, slot2;
    logic [23:0]       pixOut;
    logic              pixValid, frameDone, fetchEn, aborting;

    logic transfer, busy, restart, abortStart, canIssue, canSample, pixelDone, incFlight;

    assign transfer   = pixValid && bus.PixelReady;
    // A push already on the bus counts as outstanding even before inFlight catches it.
    assign busy       = (inFlight != '0) || pixValid || (reqState == REQ_PUSH);
    assign abortStart = bus.FrameStart && busy && !aborting;
    assign restart    = aborting ? ((inFlight == '0) && (reqState == REQ_IDLE))
                                 : (bus.FrameStart && !busy);
    assign canIssue   = fetchEn && !aborting && (reqCount < PIXTOTAL) &&
                        !bus.ReadReqQueueFull && (inFlight < INFLIGHTMAX);
    // inFlight guard keeps stray queue bytes from underflowing the count.
    assign canSample  = !bus.ReadDataQueueEmpty && (inFlight != '0) &&
                        (!pixValid || (byteIdx != 2'd2));
    assign pixelDone  = (datState == DAT_GAP) && (byteIdx == 2'd2);
    assign incFlight  = (reqState == REQ_PUSH);

    // Request FSM: one address push per pixel, idle/push/gap gives 3-cycle spacing.
    always_ff @(posedge MemClk) begin
        if (!ResetN) begin
            reqState <= REQ_IDLE;
            pushReq  <= 1'b0;
            readAddr <= BASE;
            reqCount <= '0;
        end else begin
            pushReq <= 1'b0;
            case (reqState)
                REQ_IDLE: begin
                    if (restart) begin
                        readAddr <= BASE;
                        reqCount <= '0;
                    end else if (canIssue) begin
                        reqState <= REQ_PUSH;
                        pushReq  <= 1'b1;
                    end
                end
                REQ_PUSH: begin
                    reqCount <= reqCount + CW'(1);
                    reqState <= REQ_GAP;
                end
                REQ_GAP: begin
                    readAddr <= readAddr + AWIDTH'(3);
                    reqState <= REQ_IDLE;
                end
                default: reqState <= REQ_IDLE;
            endcase
        end
    end

    // In-flight count: +1 on push, -1 when the third byte of a pixel is consumed.
    always_ff @(posedge MemClk) begin
        if (!ResetN) begin
            inFlight <= '0;
        end else if (incFlight && !pixelDone) begin
            inFlight <= inFlight + IW'(1);
        end else if (!incFlight && pixelDone) begin
            inFlight <= inFlight - IW'(1);
        end
    end

    // Data FSM: sample head byte, then pulse pop, then advance the byte index.
    always_ff @(posedge MemClk) begin
        if (!ResetN) begin
            datState  <= DAT_WAIT;
            popStrobe <= 1'b0;
            byteIdx   <= 2'd0;
            slot0     <= '0;
            slot1     <= '0;
            slot2     <= '0;
        end else begin
            popStrobe <= 1'b0;
            case (datState)
                DAT_WAIT: begin
                    if (canSample) begin
                        case (byteIdx)
                            2'd0:    slot0 <= bus.ReadDataIn;
                            2'd1:    slot1 <= bus.ReadDataIn;
                            default: slot2 <= bus.ReadDataIn;
                        endcase
                        popStrobe <= 1'b1;
                        datState  <= DAT_POP;
                    end
                end
                DAT_POP: datState <= DAT_GAP;
                DAT_GAP: begin
                    byteIdx  <= (byteIdx == 2'd2) ? 2'd0 : byteIdx + 2'd1;
                    datState <= DAT_WAIT;
                end
                default: datState <= DAT_WAIT;
            endcase
        end
    end

    // Pixel register: load on completed pixel, drop on transfer, forced empty while aborting.
    always_ff @(posedge MemClk) begin
        if (!ResetN) begin
            pixValid <= 1'b0;
            pixOut   <= '0;
        end else if (aborting || abortStart) begin
            pixValid <= 1'b0;
        end else if (pixelDone) begin
            pixValid <= 1'b1;
            pixOut   <= 24'({slot0, slot1, slot2});
        end else if (transfer) begin
            pixValid <= 1'b0;
        end
    end

    // Frame control: start/abort/restart and the end-of-frame pulse.
    always_ff @(posedge MemClk) begin
        if (!ResetN) begin
            fetchEn   <= 1'b0;
            aborting  <= 1'b0;
            pixCount  <= '0;
            frameDone <= 1'b0;
        end else begin
            frameDone <= 1'b0;
            if (restart) begin
                fetchEn  <= 1'b1;
                aborting <= 1'b0;
                pixCount <= '0;
            end else if (abortStart) begin
                fetchEn  <= 1'b0;
                aborting <= 1'b1;
            end else if (transfer && !aborting) begin
                pixCount <= pixCount + CW'(1);
                if (pixCount == PIXLAST) begin
                    frameDone <= 1'b1;
                    fetchEn   <= 1'b0;
                end
            end
        end
    end

`ifdef SCAN_FETCH_UNDERRUN_EN
    logic        underrunHit, underrun;
    logic [15:0] underrunCount;
    assign underrunHit = bus.PixelReady && !pixValid && fetchEn && !aborting && (pixCount < PIXTOTAL);

    // Underrun tracking: consumer ready with no pixel while the frame is still being fetched.
    always_ff @(posedge MemClk) begin
        if (!ResetN) begin
            underrun      <= 1'b0;
            underrunCount <= '0;
        end else begin
            underrun <= underrunHit && !bus.FrameStart;
            if (bus.FrameStart) begin
                underrunCount <= '0;
            end else if (underrunHit && (underrunCount != 16'hFFFF)) begin
                underrunCount <= underrunCount + 16'd1;
            end
        end
    end
    assign bus.Underrun      = underrun;
    assign bus.UnderrunCount = underrunCount;
`endif

    assign bus.ReadAddrOut    = readAddr;
    assign bus.PushReadReq    = pushReq;
    assign bus.ReadDataClkOut = popStrobe;
    assign bus.PixelOut       = pixOut;
    assign bus.PixelValid     = pixValid;
    assign bus.FrameDone      = frameDone;
endmodule

// File: tb/tb_vmmu_scan_fetch.sv
// Directed bench for vmmu_scan_fetch: small 4-pixel frame at 0x100 with a behavioural VMMU.
// Memory byte at address a is ((a[7:0]+1)*0x11), so pixels are 112233, 445566, 778899, AABBCC.
module tb_vmmu_scan_fetch;
    localparam int AW = 18;

    logic MemClk;
    logic ResetN;
    logic forceEmpty;
    logic qEmpty;
    logic [7:0] qHead;

    vmmu_scan_fetch_if #(.AWIDTH(AW), .DWIDTH(8)) bus ();

    vmmu_scan_fetch #(
        .AWIDTH(AW), .DWIDTH(8), .BASEADDR('h100), .PIXCOUNT(4), .MAXINFLIGHT(2)
    ) dut (
        .MemClk(MemClk),
        .ResetN(ResetN),
        .bus(bus)
    );

    initial begin
        MemClk = 1'b0;
        forever #5 MemClk = ~MemClk;
    end

    logic [AW-1:0] reqLog[$];
    logic [23:0]   pixLog[$];
    logic [7:0]    dq[$];
    int pushCnt = 0;
    int popCnt  = 0;
    int doneCnt = 0;
    int nCmp    = 0;
    int nFail   = 0;

    logic [AW-1:0] expAddr [4] = '{18'h100, 18'h103, 18'h106, 18'h109};
    logic [23:0]   expPix  [4] = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};

    function automatic logic [7:0] memByte(input logic [AW-1:0] a);
        logic [7:0] lo;
        lo = a[7:0] + 8'd1;
        return 8'(lo * 8'h11);
    endfunction

    // Behavioural VMMU: each push queues 3 bytes; a pop strobe removes the head byte.
    initial begin
        qEmpty = 1'b1;
        qHead  = 8'h00;
        forever begin
            @(posedge MemClk);
            if (!ResetN) begin
                dq.delete();
            end else begin
                if (bus.PushReadReq) begin
                    reqLog.push_back(bus.ReadAddrOut);
                    pushCnt++;
                    for (int i = 0; i < 3; i++) dq.push_back(memByte(bus.ReadAddrOut + AW'(i)));
                end
                if (bus.ReadDataClkOut && dq.size() > 0) begin
                    void'(dq.pop_front());
                    popCnt++;
                end
                if (bus.PixelValid && bus.PixelReady) pixLog.push_back(bus.PixelOut);
                if (bus.FrameDone) doneCnt++;
            end
            #1;
            qEmpty = (dq.size() == 0);
            qHead  = qEmpty ? 8'h00 : dq[0];
        end
    end

    assign bus.ReadDataQueueEmpty = qEmpty || forceEmpty;
    assign bus.ReadDataIn         = qHead;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkFrame(input string tag, input int rb, input int pb);
        check({tag, "_nreq"}, 32'(reqLog.size() - rb), 32'd4);
        check({tag, "_npix"}, 32'(pixLog.size() - pb), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_addr%0d", tag, i),
                  (rb + i < reqLog.size()) ? 32'(reqLog[rb + i]) : 32'hFFFF_FFFF, 32'(expAddr[i]));
            check($sformatf("%s_pix%0d", tag, i),
                  (pb + i < pixLog.size()) ? 32'(pixLog[pb + i]) : 32'hFFFF_FFFF, 32'(expPix[i]));
        end
    endtask

    task automatic pulseFrameStart();
        bus.FrameStart = 1'b1;
        @(negedge MemClk);
        bus.FrameStart = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge MemClk);
            if (bus.FrameDone) hit = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(hit), 32'd1);
        @(negedge MemClk);
        check({tag, "_done_1cyc"}, 32'(bus.FrameDone), 32'd0);
    endtask

    int  rb, pb, db, pcb, b, mo, outst;
    bit  hit;

    initial begin
        ResetN = 1'b0;
        forceEmpty = 1'b0;
        bus.FrameStart = 1'b0;
        bus.ReadReqQueueFull = 1'b0;
        bus.PixelReady = 1'b1;
        repeat (3) @(negedge MemClk);

        // Reset state
        check("rst_push",  32'(bus.PushReadReq), 32'd0);
        check("rst_pop",   32'(bus.ReadDataClkOut), 32'd0);
        check("rst_valid", 32'(bus.PixelValid), 32'd0);
        check("rst_pix",   32'(bus.PixelOut), 32'd0);
        check("rst_done",  32'(bus.FrameDone), 32'd0);
        check("rst_addr",  32'(bus.ReadAddrOut), 32'h100);
        ResetN = 1'b1;
        repeat (5) @(negedge MemClk);
        check("idle_nreq", 32'(reqLog.size()), 32'd0);

        // Test 1: basic frame
        rb = reqLog.size(); pb = pixLog.size(); db = doneCnt;
        pulseFrameStart();
        @(negedge MemClk);
        check("t1_first_push", 32'(bus.PushReadReq), 32'd1);
        check("t1_first_addr", 32'(bus.ReadAddrOut), 32'h100);
        @(negedge MemClk);
        check("t1_push_1cyc", 32'(bus.PushReadReq), 32'd0);
        waitDone("t1");
        repeat (20) @(negedge MemClk);
        checkFrame("t1", rb, pb);
        check("t1_done_cnt", 32'(doneCnt - db), 32'd1);

        // Test 2: request queue full for 10 cycles mid-frame
        rb = reqLog.size(); pb = pixLog.size(); db = doneCnt;
        pulseFrameStart();
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (reqLog.size() - rb >= 2) hit = 1'b1;
            else @(negedge MemClk);
        end
        check("t2_two_reqs", 32'(hit), 32'd1);
        bus.ReadReqQueueFull = 1'b1;
        repeat (10) @(negedge MemClk);
        check("t2_stall_nreq", 32'(reqLog.size() - rb), 32'd2);
        bus.ReadReqQueueFull = 1'b0;
        waitDone("t2");
        repeat (20) @(negedge MemClk);
        checkFrame("t2", rb, pb);
        check("t2_done_cnt", 32'(doneCnt - db), 32'd1);

        // Test 3: consumer stalled, in-flight limit and stable PixelOut
        rb = reqLog.size(); pb = pixLog.size(); pcb = popCnt; mo = 0;
        bus.PixelReady = 1'b0;
        pulseFrameStart();
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge MemClk);
            if (bus.PixelValid) hit = 1'b1;
        end
        check("t3_valid_seen", 32'(hit), 32'd1);
        check("t3_pix_first", 32'(bus.PixelOut), 32'h112233);
        for (int i = 0; i < 40; i++) begin
            @(negedge MemClk);
            outst = pushCnt - popCnt / 3;
            if (outst > mo) mo = outst;
        end
        check("t3_pix_held", 32'(bus.PixelOut), 32'h112233);
        check("t3_valid_held", 32'(bus.PixelValid), 32'd1);
        check("t3_nreq", 32'(reqLog.size() - rb), 32'd3);
        check("t3_npop", 32'(popCnt - pcb), 32'd5);
        check("t3_max_outst", 32'(mo <= 2), 32'd1);
        bus.PixelReady = 1'b1;
        waitDone("t3");
        repeat (20) @(negedge MemClk);
        checkFrame("t3", rb, pb);

        // Test 4: abort after 2 requests and 1 returned byte
        rb = reqLog.size(); pb = pixLog.size(); db = doneCnt; pcb = popCnt;
        forceEmpty = 1'b1;
        pulseFrameStart();
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge MemClk);
            if (reqLog.size() - rb >= 2) hit = 1'b1;
        end
        check("t4_two_reqs", 32'(hit), 32'd1);
        forceEmpty = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge MemClk);
            if (popCnt - pcb >= 1) hit = 1'b1;
        end
        forceEmpty = 1'b1;
        check("t4_one_pop", 32'(hit), 32'd1);
        repeat (3) @(negedge MemClk);
        check("t4_pop_held", 32'(popCnt - pcb), 32'd1);
        pulseFrameStart();
        forceEmpty = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge MemClk);
            if (bus.PixelValid) hit = 1'b1;
            if (reqLog.size() - rb >= 3) break;
        end
        check("t4_no_valid", 32'(hit), 32'd0);
        check("t4_nreq_restart", 32'(reqLog.size() - rb), 32'd3);
        check("t4_restart_addr", (reqLog.size() - rb >= 3) ? 32'(reqLog[rb + 2]) : 32'hFFFF_FFFF, 32'h100);
        check("t4_discard_pops", 32'(popCnt - pcb), 32'd6);
        check("t4_no_pix", 32'(pixLog.size() - pb), 32'd0);
        waitDone("t4");
        repeat (20) @(negedge MemClk);
        checkFrame("t4", rb + 2, pb);
        check("t4_done_cnt", 32'(doneCnt - db), 32'd1);

        // Test 5: reset during a push strobe
        pulseFrameStart();
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge MemClk);
            if (bus.PushReadReq) hit = 1'b1;
        end
        check("t5_push_seen", 32'(hit), 32'd1);
        b = reqLog.size();
        ResetN = 1'b0;
        @(negedge MemClk);
        check("t5_push",  32'(bus.PushReadReq), 32'd0);
        check("t5_pop",   32'(bus.ReadDataClkOut), 32'd0);
        check("t5_valid", 32'(bus.PixelValid), 32'd0);
        check("t5_addr",  32'(bus.ReadAddrOut), 32'h100);
        ResetN = 1'b1;
        repeat (10) @(negedge MemClk);
        check("t5_idle_nreq", 32'(reqLog.size() - b), 32'd0);
        check("t5_idle_pop",  32'(bus.ReadDataClkOut), 32'd0);

`ifdef SCAN_FETCH_UNDERRUN_EN
        // Underrun: 5 ready cycles with no data available
        bus.PixelReady = 1'b0;
        forceEmpty = 1'b1;
        pulseFrameStart();
        bus.PixelReady = 1'b1;
        repeat (5) @(negedge MemClk);
        bus.PixelReady = 1'b0;
        check("ur_pulse", 32'(bus.Underrun), 32'd1);
        @(negedge MemClk);
        check("ur_count", 32'(bus.UnderrunCount), 32'd5);
        check("ur_pulse_off", 32'(bus.Underrun), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end
endmodule
